// File: rtl/register_file_sb.sv
// -----------------------------------------------------------------------------
// register_file_sb
//
// Pipeline register file with two write ports (dual writeback), two
// combinational read ports, a debug read port and a per-register busy
// scoreboard used by the ID stage for hazard detection and stalls.
//
// Parameters
//   DATA_WIDTH : width of each register and of every data port
//   ADDR_WIDTH : register address width, depth = 2**ADDR_WIDTH
//   ZERO_REG   : 1 -> register 0 reads as zero, is never written, never busy
//   BYPASS     : 1 -> a same-cycle write is forwarded to a matching read port
//
// Ports
//   clock, reset                      : rising-edge clock, async active-low reset
//   readAddressA/B                    : read port addresses
//   readDataA/B                       : read data (stored value or bypassed)
//   readBusyA/B                       : scoreboard busy bit for the read address
//   write0Enable/Address/Data         : write port 0 (older pipe)
//   write1Enable/Address/Data         : write port 1 (younger pipe, wins ties)
//   issueEnable, issueAddress         : destination register issued this cycle
//   debug_addr, debug_data            : debug read, stored value only
//
// Writes and scoreboard updates happen on the rising edge while reset is
// high. While reset is low every output reads zero and bypass is disabled.
// -----------------------------------------------------------------------------
module register_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] readAddressA,
  output logic [DATA_WIDTH-1:0] readDataA,
  output logic                  readBusyA,
  input  logic [ADDR_WIDTH-1:0] readAddressB,
  output logic [DATA_WIDTH-1:0] readDataB,
  output logic                  readBusyB,
  input  logic                  write0Enable,
  input  logic [ADDR_WIDTH-1:0] write0Address,
  input  logic [DATA_WIDTH-1:0] write0Data,
  input  logic                  write1Enable,
  input  logic [ADDR_WIDTH-1:0] write1Address,
  input  logic [DATA_WIDTH-1:0] write1Data,
  input  logic                  issueEnable,
  input  logic [ADDR_WIDTH-1:0] issueAddress,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [DATA_WIDTH-1:0] debug_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_next;

  // Address-0 detection, only meaningful when register 0 is hardwired.
  logic w0_zero, w1_zero, iss_zero, ra_zero, rb_zero, dbg_zero;

  assign w0_zero  = ZR && (write0Address == '0);
  assign w1_zero  = ZR && (write1Address == '0);
  assign iss_zero = ZR && (issueAddress  == '0);
  assign ra_zero  = ZR && (readAddressA  == '0);
  assign rb_zero  = ZR && (readAddressB  == '0);
  assign dbg_zero = ZR && (debug_addr    == '0);

  // Qualified strobes: writes and issues to a hardwired zero are dropped.
  logic wr0_ok, wr1_ok, iss_ok;

  assign wr0_ok = write0Enable && !w0_zero;
  assign wr1_ok = write1Enable && !w1_zero;
  assign iss_ok = issueEnable  && !iss_zero;

  // ---------------------------------------------------------------------------
  // Register storage. Port 1 is assigned last so it wins an address tie.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr0_ok) begin
        regs[write0Address] <= write0Data;
      end
      if (wr1_ok) begin
        regs[write1Address] <= write1Data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard. Writeback clears first, then issue sets, so an issue on the
  // same edge as a writeback to the same register leaves it busy: the issuing
  // instruction is the newer producer. No counting: a single clear frees it.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_next = busy;
    if (wr0_ok) begin
      busy_next[write0Address] = 1'b0;
    end
    if (wr1_ok) begin
      busy_next[write1Address] = 1'b0;
    end
    if (iss_ok) begin
      busy_next[issueAddress] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Bypass hit detection per read port. Suppressed while reset is low because
  // the write will be dropped, so forwarding it would show data that never
  // lands in the file.
  // ---------------------------------------------------------------------------
  logic hit0_a, hit1_a, hit0_b, hit1_b;
  logic iss_a, iss_b;

  assign hit0_a = BP && reset && wr0_ok && (write0Address == readAddressA);
  assign hit1_a = BP && reset && wr1_ok && (write1Address == readAddressA);
  assign hit0_b = BP && reset && wr0_ok && (write0Address == readAddressB);
  assign hit1_b = BP && reset && wr1_ok && (write1Address == readAddressB);

  // A same-cycle issue to the read address keeps the register busy even when
  // a writeback is being forwarded, matching the post-edge scoreboard state.
  assign iss_a = issueEnable && (issueAddress == readAddressA);
  assign iss_b = issueEnable && (issueAddress == readAddressB);

  // ---------------------------------------------------------------------------
  // Read port A
  // ---------------------------------------------------------------------------
  always_comb begin
    readDataA = regs[readAddressA];
    readBusyA = busy[readAddressA];
    if (hit1_a) begin
      readDataA = write1Data;
    end else if (hit0_a) begin
      readDataA = write0Data;
    end
    if ((hit0_a || hit1_a) && !iss_a) begin
      readBusyA = 1'b0;
    end
    if (!reset || ra_zero) begin
      readDataA = '0;
      readBusyA = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port B
  // ---------------------------------------------------------------------------
  always_comb begin
    readDataB = regs[readAddressB];
    readBusyB = busy[readAddressB];
    if (hit1_b) begin
      readDataB = write1Data;
    end else if (hit0_b) begin
      readDataB = write0Data;
    end
    if ((hit0_b || hit1_b) && !iss_b) begin
      readBusyB = 1'b0;
    end
    if (!reset || rb_zero) begin
      readDataB = '0;
      readBusyB = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Debug port: stored value only, never bypassed.
  // ---------------------------------------------------------------------------
  always_comb begin
    debug_data = regs[debug_addr];
    if (!reset || dbg_zero) begin
      debug_data = '0;
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// -----------------------------------------------------------------------------
// tb_register_file_sb
//
// Drives a BYPASS=1 and a BYPASS=0 instance from the same stimulus.
// Directed table vectors, hand-written reset/latency sequences, then a
// randomized phase compared against an array-based reference model.
// -----------------------------------------------------------------------------
module tb_register_file_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 1 << AW;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  logic [AW-1:0] readAddressA, readAddressB, debug_addr;
  logic          write0Enable, write1Enable, issueEnable;
  logic [AW-1:0] write0Address, write1Address, issueAddress;
  logic [DW-1:0] write0Data, write1Data;

  logic [DW-1:0] rd_a, rd_b, dbg;
  logic          bz_a, bz_b;
  logic [DW-1:0] nb_rd_a, nb_rd_b, nb_dbg;
  logic          nb_bz_a, nb_bz_b;

  register_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1), .BYPASS(1)) dut (
    .clock(clock), .reset(reset),
    .readAddressA(readAddressA), .readDataA(rd_a), .readBusyA(bz_a),
    .readAddressB(readAddressB), .readDataB(rd_b), .readBusyB(bz_b),
    .write0Enable(write0Enable), .write0Address(write0Address), .write0Data(write0Data),
    .write1Enable(write1Enable), .write1Address(write1Address), .write1Data(write1Data),
    .issueEnable(issueEnable), .issueAddress(issueAddress),
    .debug_addr(debug_addr), .debug_data(dbg)
  );

  register_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clock(clock), .reset(reset),
    .readAddressA(readAddressA), .readDataA(nb_rd_a), .readBusyA(nb_bz_a),
    .readAddressB(readAddressB), .readDataB(nb_rd_b), .readBusyB(nb_bz_b),
    .write0Enable(write0Enable), .write0Address(write0Address), .write0Data(write0Data),
    .write1Enable(write1Enable), .write1Address(write1Address), .write1Data(write1Data),
    .issueEnable(issueEnable), .issueAddress(issueAddress),
    .debug_addr(debug_addr), .debug_data(nb_dbg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Reference model: plain arrays updated from the behavioural rules
  // ---------------------------------------------------------------------------
  logic [DW-1:0] ref_mem  [DEPTH];
  bit            ref_busy [DEPTH];

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]  = '0;
      ref_busy[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      if (write0Enable && write0Address != 0) ref_mem[write0Address] = write0Data;
      if (write1Enable && write1Address != 0) ref_mem[write1Address] = write1Data;
      if (write0Enable && write0Address != 0) ref_busy[write0Address] = 1'b0;
      if (write1Enable && write1Address != 0) ref_busy[write1Address] = 1'b0;
      if (issueEnable && issueAddress != 0) ref_busy[issueAddress] = 1'b1;
    end
  endtask

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a, input bit bp);
    if (!reset || a == 0) return '0;
    if (bp && write1Enable && write1Address == a) return write1Data;
    if (bp && write0Enable && write0Address == a) return write0Data;
    return ref_mem[a];
  endfunction

  function automatic logic m_busy(input logic [AW-1:0] a, input bit bp);
    if (!reset || a == 0) return 1'b0;
    if (bp && ((write1Enable && write1Address == a) || (write0Enable && write0Address == a))
        && !(issueEnable && issueAddress == a)) return 1'b0;
    return ref_busy[a];
  endfunction

  function automatic logic [DW-1:0] m_debug(input logic [AW-1:0] a);
    if (!reset || a == 0) return '0;
    return ref_mem[a];
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " rdA"},    rd_a,             m_read(readAddressA, 1'b1));
    chk({tag, " rdB"},    rd_b,             m_read(readAddressB, 1'b1));
    chk({tag, " busyA"},  {31'd0, bz_a},    {31'd0, m_busy(readAddressA, 1'b1)});
    chk({tag, " busyB"},  {31'd0, bz_b},    {31'd0, m_busy(readAddressB, 1'b1)});
    chk({tag, " dbg"},    dbg,              m_debug(debug_addr));
    chk({tag, " nb rdA"}, nb_rd_a,          m_read(readAddressA, 1'b0));
    chk({tag, " nb rdB"}, nb_rd_b,          m_read(readAddressB, 1'b0));
    chk({tag, " nb busyA"}, {31'd0, nb_bz_a}, {31'd0, m_busy(readAddressA, 1'b0)});
    chk({tag, " nb busyB"}, {31'd0, nb_bz_b}, {31'd0, m_busy(readAddressB, 1'b0)});
    chk({tag, " nb dbg"}, nb_dbg,           m_debug(debug_addr));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks: inputs change just after the falling edge
  // ---------------------------------------------------------------------------
  task automatic idle();
    write0Enable = 0; write0Address = '0; write0Data = '0;
    write1Enable = 0; write1Address = '0; write1Data = '0;
    issueEnable  = 0; issueAddress  = '0;
  endtask

  // One rising edge (model follows it), then back to the falling edge.
  task automatic cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          w0e; logic [AW-1:0] w0a; logic [DW-1:0] w0d;
    logic          w1e; logic [AW-1:0] w1a; logic [DW-1:0] w1d;
    logic          ie;  logic [AW-1:0] ia;
    logic [AW-1:0] ra, rb, da;
    logic [DW-1:0] ea, eb;
    logic          eba, ebb;
    logic [DW-1:0] ed;
    logic [DW-1:0] nea;
    logic          nba;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mkv(
    input logic w0e, input logic [AW-1:0] w0a, input logic [DW-1:0] w0d,
    input logic w1e, input logic [AW-1:0] w1a, input logic [DW-1:0] w1d,
    input logic ie,  input logic [AW-1:0] ia,
    input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic [AW-1:0] da,
    input logic [DW-1:0] ea, input logic [DW-1:0] eb,
    input logic eba, input logic ebb, input logic [DW-1:0] ed,
    input logic [DW-1:0] nea, input logic nba);
    vec_t v;
    v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
    v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
    v.ie = ie; v.ia = ia; v.ra = ra; v.rb = rb; v.da = da;
    v.ea = ea; v.eb = eb; v.eba = eba; v.ebb = ebb; v.ed = ed;
    v.nea = nea; v.nba = nba;
    return v;
  endfunction

  initial begin
    idle();
    readAddressA = '0; readAddressB = '0; debug_addr = '0;
    model_clear();

    //                w0e w0a w0d           w1e w1a w1d           ie ia  ra  rb  da  ea            eb            eba ebb ed            nea           nba
    // Dual write to r7: port 1 wins, visible combinationally with bypass.
    vecs[0]  = mkv(1, 7,  32'hAAAA0000, 1, 7, 32'h5555FFFF, 0, 0,  7,  0,  7, 32'h5555FFFF, 32'h0,        0, 0, 32'h0,        32'h0,        0);
    vecs[1]  = mkv(0, 0,  32'h0,        0, 0, 32'h0,        0, 0,  7,  7,  7, 32'h5555FFFF, 32'h5555FFFF, 0, 0, 32'h5555FFFF, 32'h5555FFFF, 0);
    // Zero register: writes and issue to r0 have no effect, even bypassed.
    vecs[2]  = mkv(1, 0,  32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0,  0,  0,  0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        0);
    vecs[3]  = mkv(0, 0,  32'h0,        0, 0, 32'h0,        0, 0,  0,  0,  0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        0);
    // Scoreboard: issue r3, busy from next cycle.
    vecs[4]  = mkv(0, 0,  32'h0,        0, 0, 32'h0,        1, 3,  3,  0,  3, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        0);
    vecs[5]  = mkv(0, 0,  32'h0,        0, 0, 32'h0,        0, 0,  3,  3,  3, 32'h0,        32'h0,        1, 1, 32'h0,        32'h0,        1);
    // Write r3 plus issue r3 on one edge: set wins, busy stays.
    vecs[6]  = mkv(1, 3,  32'h42,       0, 0, 32'h0,        1, 3,  3,  3,  3, 32'h42,       32'h42,       1, 1, 32'h0,        32'h0,        1);
    vecs[7]  = mkv(0, 0,  32'h0,        0, 0, 32'h0,        0, 0,  3,  3,  3, 32'h42,       32'h42,       1, 1, 32'h42,       32'h42,       1);
    // Plain writeback of r3 frees it; bypass forces busy low this cycle.
    vecs[8]  = mkv(0, 0,  32'h0,        1, 3, 32'h99,       0, 0,  3,  3,  3, 32'h99,       32'h99,       0, 0, 32'h42,       32'h42,       1);
    vecs[9]  = mkv(0, 0,  32'h0,        0, 0, 32'h0,        0, 0,  3,  3,  3, 32'h99,       32'h99,       0, 0, 32'h99,       32'h99,       0);
    // Debug port is never bypassed.
    vecs[10] = mkv(1, 12, 32'hDEAD,     0, 0, 32'h0,        0, 0, 12,  3, 12, 32'hDEAD,     32'h99,       0, 0, 32'h0,        32'h0,        0);
    vecs[11] = mkv(0, 0,  32'h0,        0, 0, 32'h0,        0, 0, 12, 12, 12, 32'hDEAD,     32'hDEAD,     0, 0, 32'hDEAD,     32'hDEAD,     0);
    vecs[12] = mkv(0, 0,  32'h0,        0, 0, 32'h0,        0, 0, 12,  0,  0, 32'hDEAD,     32'h0,        0, 0, 32'h0,        32'hDEAD,     0);

    // Reset state
    @(negedge clock);
    #2;
    chk("reset rdA", rd_a, '0);
    chk("reset busyA", {31'd0, bz_a}, '0);
    chk("reset dbg", dbg, '0);
    @(negedge clock);
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      write0Enable = vecs[i].w0e; write0Address = vecs[i].w0a; write0Data = vecs[i].w0d;
      write1Enable = vecs[i].w1e; write1Address = vecs[i].w1a; write1Data = vecs[i].w1d;
      issueEnable  = vecs[i].ie;  issueAddress  = vecs[i].ia;
      readAddressA = vecs[i].ra;  readAddressB  = vecs[i].rb;  debug_addr = vecs[i].da;
      #2;
      chk($sformatf("vec%0d rdA", i),   rd_a,             vecs[i].ea);
      chk($sformatf("vec%0d rdB", i),   rd_b,             vecs[i].eb);
      chk($sformatf("vec%0d busyA", i), {31'd0, bz_a},    {31'd0, vecs[i].eba});
      chk($sformatf("vec%0d busyB", i), {31'd0, bz_b},    {31'd0, vecs[i].ebb});
      chk($sformatf("vec%0d dbg", i),   dbg,              vecs[i].ed);
      chk($sformatf("vec%0d nb rdA", i),   nb_rd_a,          vecs[i].nea);
      chk($sformatf("vec%0d nb busyA", i), {31'd0, nb_bz_a}, {31'd0, vecs[i].nba});
      cycle();
    end

    // Asynchronous reset mid-cycle with preloaded state
    idle();
    write0Enable = 1; write0Address = 5; write0Data = 32'h1234;
    issueEnable  = 1; issueAddress  = 5;
    cycle();
    idle();
    readAddressA = 5; readAddressB = 5; debug_addr = 5;
    #2;
    chk("preload rdA", rd_a, 32'h1234);
    chk("preload busyA", {31'd0, bz_a}, 32'd1);
    reset = 1'b0;
    model_clear();
    #1;
    chk("async rst rdA", rd_a, '0);
    chk("async rst busyA", {31'd0, bz_a}, '0);
    chk("async rst dbg", dbg, '0);
    chk("async rst nb rdA", nb_rd_a, '0);
    cycle();
    // Writes and issues during reset are dropped and not bypassed.
    write0Enable = 1; write0Address = 5; write0Data = 32'hBEEF;
    issueEnable  = 1; issueAddress  = 5;
    #2;
    chk("in rst bypass rdA", rd_a, '0);
    chk("in rst busyA", {31'd0, bz_a}, '0);
    cycle();
    idle();
    #2;
    reset = 1'b1;
    #1;
    chk("post rst rdA", rd_a, '0);
    chk("post rst busyA", {31'd0, bz_a}, '0);
    chk("post rst nb rdA", nb_rd_a, '0);
    chk("post rst dbg", dbg, '0);
    cycle();
    // First edge after reset performs a normal write.
    write0Enable = 1; write0Address = 9; write0Data = 32'h77;
    readAddressA = 9;
    #2;
    chk("nb old r9", nb_rd_a, '0);
    chk("bp new r9", rd_a, 32'h77);
    cycle();
    idle();
    #2;
    chk("nb r9 after edge", nb_rd_a, 32'h77);
    cycle();

    // Randomized phase against the reference model
    for (int n = 0; n < 400; n++) begin
      int hi;
      hi = (n % 8 == 0) ? DEPTH - 1 : 7;
      write0Enable  = ($urandom_range(0, 1) == 1);
      write0Address = AW'($urandom_range(0, hi));
      write0Data    = $urandom;
      write1Enable  = ($urandom_range(0, 2) == 0);
      write1Address = AW'($urandom_range(0, hi));
      write1Data    = $urandom;
      issueEnable   = ($urandom_range(0, 1) == 1);
      issueAddress  = AW'($urandom_range(0, hi));
      readAddressA  = AW'($urandom_range(0, hi));
      readAddressB  = AW'($urandom_range(0, hi));
      debug_addr    = AW'($urandom_range(0, hi));
      #2;
      check_all($sformatf("rnd%0d", n));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
